// File: rtl/weight_sequencer.sv
// Weight sequencer: streams weights from memory alongside input samples to a MAC.
// Optional runtime weight loading through the cfg port is enabled by WEIGHT_LOAD_EN.
module weight_sequencer #(
   parameter int numWeight    = 3,
   parameter int dataWidth    = 16,
   parameter int addressWidth = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    x_valid,
   input  logic [dataWidth-1:0]    x_in,
   input  logic                    cfg_valid,
   input  logic [addressWidth-1:0] cfg_addr,
   input  logic [dataWidth-1:0]    cfg_data,
   output logic                    cfg_ready,
   output logic                    mem_wen,
   output logic [addressWidth-1:0] mem_wadd,
   output logic [dataWidth-1:0]    mem_win,
   output logic                    mem_ren,
   output logic [addressWidth-1:0] mem_radd,
   input  logic [dataWidth-1:0]    mem_wout,
   output logic                    mac_valid,
   output logic                    mac_last,
   output logic [dataWidth-1:0]    mac_x,
   output logic [dataWidth-1:0]    mac_w,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              state_dbg
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

   logic [1:0]              state;
   logic [1:0]              state_next;
   logic [addressWidth-1:0] count;
   logic [dataWidth-1:0]    x_d;
   logic                    accept;
   logic                    mac_valid_q;
   logic                    mac_last_q;

   // Handshake: a cfg write transfers in any cycle where cfg_valid and cfg_ready are both 1;
   // x_valid has no back-pressure and is only consumed while a pass is running.
   assign accept   = (state == RUN) && x_valid;
   assign mem_ren  = accept;
   assign mem_radd = count;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && (count == LAST_ADDR)) state_next = DRAIN;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         x_d         <= '0;
         mac_valid_q <= 1'b0;
         mac_last_q  <= 1'b0;
      end else begin
         state       <= state_next;
         mac_valid_q <= accept;
         mac_last_q  <= accept && (count == LAST_ADDR);
         if ((state == IDLE) && start) begin
            count <= '0;
         end else if (accept) begin
            count <= (count == LAST_ADDR) ? '0 : count + 1'b1;
         end
         if (accept) x_d <= x_in;
      end
   end

   // Read data arrives one cycle after mem_ren, so it lines up with the delayed sample.
   assign mac_valid = mac_valid_q;
   assign mac_last  = mac_last_q;
   assign mac_x     = mac_valid_q ? x_d : '0;
   assign mac_w     = mac_valid_q ? mem_wout : '0;
   assign busy      = (state != IDLE);
   assign done      = (state == DRAIN);
   assign state_dbg = state;

`ifdef WEIGHT_LOAD_EN
   localparam logic [addressWidth:0] NUM_W = (addressWidth + 1)'(numWeight);
   logic addr_ok;

   // Out-of-range writes are still consumed so a host never stalls on a bad address.
   assign cfg_ready = (state == IDLE) && !start;
   assign addr_ok   = {1'b0, cfg_addr} < NUM_W;
   assign mem_wen   = cfg_valid && cfg_ready && addr_ok;
   assign mem_wadd  = mem_wen ? cfg_addr : '0;
   assign mem_win   = mem_wen ? cfg_data : '0;
`else
   logic unused_cfg;

   assign cfg_ready  = 1'b0;
   assign mem_wen    = 1'b0;
   assign mem_wadd   = '0;
   assign mem_win    = '0;
   assign unused_cfg = ^{cfg_valid, cfg_addr, cfg_data};
`endif

endmodule

// File: tb/tb_weight_sequencer.sv
// Bench for weight_sequencer: directed scenarios plus a randomized stream checked
// against a pass-level model with an expected-pair queue.
module tb_weight_sequencer;
   localparam int NW = 3;
   localparam int DW = 16;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          x_valid = 1'b0;
   logic [DW-1:0] x_in = '0;
   logic          cfg_valid = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic          cfg_ready, mem_wen, mem_ren;
   logic [AW-1:0] mem_wadd, mem_radd;
   logic [DW-1:0] mem_win, mem_wout;
   logic          mac_valid, mac_last, busy, done;
   logic [DW-1:0] mac_x, mac_w;
   logic [1:0]    state_dbg;

   weight_sequencer #(.numWeight(NW), .dataWidth(DW), .addressWidth(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x_valid(x_valid), .x_in(x_in),
      .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .mem_wen(mem_wen), .mem_wadd(mem_wadd), .mem_win(mem_win),
      .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_wout(mem_wout),
      .mac_valid(mac_valid), .mac_last(mac_last), .mac_x(mac_x), .mac_w(mac_w),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // ---------------- clock / memory fixture ----------------
   always #5 clk = ~clk;

   logic [DW-1:0] ram [2**AW];
   logic          preload = 1'b1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2**AW; i++) ram[i] <= DW'(17 * (i + 1));
      end else if (mem_wen) begin
         ram[mem_wadd] <= mem_win;
      end
      if (mem_ren) mem_wout <= ram[mem_radd];
   end

   // ---------------- reference model / scoreboard ----------------
   int              n_cmp = 0;
   int              n_err = 0;
   logic [DW-1:0]   ref_w [2**AW];
   bit              m_run = 0;
   bit              m_drain = 0;
   int              taken = 0;
   bit              p_valid = 0;
   logic [2*DW:0]   exp_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model, advance the model.
   task automatic step(input bit s, input bit xv, input logic [DW-1:0] x,
                       input bit cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      logic [2*DW:0] e;
      bit exp_ren, exp_rdy, exp_wen, was_idle;
      start = s; x_valid = xv; x_in = x; cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
      #1;
      was_idle = !m_run && !m_drain;
      exp_ren  = m_run && xv;
`ifdef WEIGHT_LOAD_EN
      exp_rdy  = was_idle && !s;
`else
      exp_rdy  = 1'b0;
`endif
      exp_wen  = cv && exp_rdy && (int'(ca) < NW);
      check_eq("busy", busy, m_run || m_drain);
      check_eq("done", done, m_drain);
      check_eq("mem_ren", mem_ren, exp_ren);
      if (exp_ren) check_eq("mem_radd", mem_radd, taken);
      check_eq("cfg_ready", cfg_ready, exp_rdy);
      check_eq("mem_wen", mem_wen, exp_wen);
      if (exp_wen) begin
         check_eq("mem_wadd", mem_wadd, ca);
         check_eq("mem_win", mem_win, cd);
      end
`ifndef WEIGHT_LOAD_EN
      check_eq("mem_wadd_zero", mem_wadd, 0);
      check_eq("mem_win_zero", mem_win, 0);
`endif
      check_eq("mac_valid", mac_valid, p_valid);
      e = '0;
      if (p_valid && exp_q.size() > 0) e = exp_q.pop_front();
      check_eq("mac_last", mac_last, e[2*DW]);
      check_eq("mac_x", mac_x, e[2*DW-1:DW]);
      check_eq("mac_w", mac_w, e[DW-1:0]);
      @(posedge clk);
      if (exp_wen) ref_w[ca] = cd;
      p_valid = exp_ren;
      if (exp_ren) exp_q.push_back({(taken == NW - 1), x, ref_w[taken]});
      if (m_drain) begin
         m_drain = 0;
      end else if (m_run) begin
         if (xv) begin
            taken++;
            if (taken == NW) begin
               m_run = 0; m_drain = 1; taken = 0;
            end
         end
      end else if (s) begin
         m_run = 1; taken = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0);
   endtask

   // Asserts reset between edges, checks outputs clear at once, releases on a later negedge.
   task automatic do_reset();
      start = 0; cfg_valid = 0; x_valid = 1;
      rst_n = 0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_mac_valid", mac_valid, 0);
      check_eq("rst_mac_last", mac_last, 0);
      check_eq("rst_mac_x", mac_x, 0);
      check_eq("rst_mac_w", mac_w, 0);
      check_eq("rst_mem_ren", mem_ren, 0);
      m_run = 0; m_drain = 0; taken = 0; p_valid = 0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      x_valid = 0;
      rst_n = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 2**AW; i++) ref_w[i] = DW'(17 * (i + 1));
      @(negedge clk);
      do_reset();
      preload = 1'b0;

`ifdef WEIGHT_LOAD_EN
      // load weights, plus one out-of-range write that must be swallowed
      step(0, 0, '0, 1, 5'd0, 16'h0011);
      step(0, 0, '0, 1, 5'd1, 16'h0022);
      step(0, 0, '0, 1, 5'd2, 16'h0033);
      step(0, 0, '0, 1, 5'd5, 16'hdead);
`else
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1, AW'($urandom_range(0, 7)), DW'($urandom));
`endif
      // back-to-back pass
      step(1, 0, '0, 0, '0, '0);
      step(0, 1, 16'h1, 0, '0, '0);
      step(0, 1, 16'h2, 0, '0, '0);
      step(0, 1, 16'h3, 0, '0, '0);
      idle(2);
      // gapped pass
      step(1, 0, '0, 0, '0, '0);
      step(0, 1, 16'h4, 0, '0, '0);
      step(0, 0, '0, 0, '0, '0);
      step(0, 1, 16'h5, 0, '0, '0);
      step(0, 0, '0, 0, '0, '0);
      step(0, 1, 16'h6, 0, '0, '0);
      idle(2);
      // start with simultaneous cfg, then cfg held through the pass into IDLE
      step(1, 0, '0, 1, 5'd1, 16'h5555);
      for (int i = 0; i < NW; i++) step(0, 1, DW'($urandom), 1, 5'd1, 16'hbeef);
      step(0, 0, '0, 1, 5'd1, 16'hbeef);
      step(0, 0, '0, 1, 5'd1, 16'hbeef);
      idle(1);
      // reset after two of three inputs, then an immediate clean pass
      step(1, 0, '0, 0, '0, '0);
      step(0, 1, 16'h7, 0, '0, '0);
      step(0, 1, 16'h8, 0, '0, '0);
      do_reset();
      step(1, 0, '0, 0, '0, '0);
      step(0, 1, 16'h9, 0, '0, '0);
      step(0, 1, 16'ha, 0, '0, '0);
      step(0, 1, 16'hb, 0, '0, '0);
      idle(2);
      // randomized stream: starts, gaps, cfg traffic and noise in every state
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, DW'($urandom),
                 $urandom_range(0, 9) < 3, AW'($urandom_range(0, 7)), DW'($urandom));
         end
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
